// File: rtl/ir_packet_tx.sv
// ir_packet_tx -- parametrised infrared packet transmitter.
//
// Generates the IR carrier and packet framing from the system clock:
// start burst, gap, car-select burst, gap, then one burst per command bit
// (long burst for 1, short burst for 0) separated by gaps, then a one-cycle
// FINISH state that pulses DONE.
//
// Ports:
//   CLK          system clock
//   RESET        synchronous, active-low reset
//   COMMAND      command bits (bit0 right, bit1 left, bit2 back, bit3 fwd),
//                latched only when a request is accepted
//   SEND_PACKET  request, level-sampled while not busy
//   BUSY         high while a packet is being transmitted
//   DONE         one-cycle pulse when a packet completes
//   IR_LED       registered, modulated LED drive
//
// Optional feature: define IR_CMD_SANITISE_EN to clear contradictory
// direction pairs (right+left, back+fwd) at latch time. It only takes
// effect when NUM_CMD_BITS == 4; otherwise COMMAND is latched verbatim.
module ir_packet_tx #(
  parameter int unsigned CARRIER_HALF   = 1389,
  parameter int unsigned START_BURST    = 191,
  parameter int unsigned CARSEL_BURST   = 47,
  parameter int unsigned GAP            = 25,
  parameter int unsigned ASSERT_BURST   = 47,
  parameter int unsigned DEASSERT_BURST = 22,
  parameter int unsigned NUM_CMD_BITS   = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_CMD_BITS-1:0] COMMAND,
  input  logic                    SEND_PACKET,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    IR_LED
);

  localparam int unsigned LEN_A   = (START_BURST > CARSEL_BURST) ? START_BURST : CARSEL_BURST;
  localparam int unsigned LEN_B   = (ASSERT_BURST > DEASSERT_BURST) ? ASSERT_BURST : DEASSERT_BURST;
  localparam int unsigned LEN_C   = (LEN_A > LEN_B) ? LEN_A : LEN_B;
  localparam int unsigned MAX_LEN = (LEN_C > GAP) ? LEN_C : GAP;

  localparam int unsigned PH_W  = $clog2(CARRIER_HALF + 1);
  localparam int unsigned PER_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = (NUM_CMD_BITS > 1) ? $clog2(NUM_CMD_BITS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_CARSEL = 3'd3;
  localparam logic [2:0] S_BIT    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]              r_state;
  logic [2:0]              r_ret;
  logic [NUM_CMD_BITS-1:0] r_cmd;
  logic [IDX_W-1:0]        r_idx;
  logic [PH_W-1:0]         r_ph_cnt;
  logic                    r_phase;
  logic [PER_W-1:0]        r_per_cnt;
  logic                    r_led;

  logic [2:0]              w_state_nxt;
  logic [2:0]              w_ret_nxt;
  logic [NUM_CMD_BITS-1:0] w_cmd_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [PH_W-1:0]         w_ph_cnt_nxt;
  logic                    w_phase_nxt;
  logic [PER_W-1:0]        w_per_cnt_nxt;
  logic                    w_led_nxt;

  logic [NUM_CMD_BITS-1:0] w_cmd_latch;
  logic [PER_W-1:0]        w_seg_last;
  logic                    w_half_end;
  logic                    w_per_end;
  logic                    w_seg_end;
  logic                    w_last_bit;

  // Command value captured on request acceptance.
`ifdef IR_CMD_SANITISE_EN
  generate
    if (NUM_CMD_BITS == 4) begin : g_sanitise
      always_comb begin
        w_cmd_latch = COMMAND;
        if (COMMAND[0] && COMMAND[1]) w_cmd_latch[1:0] = 2'b00;
        if (COMMAND[2] && COMMAND[3]) w_cmd_latch[3:2] = 2'b00;
      end
    end else begin : g_verbatim
      assign w_cmd_latch = COMMAND;
    end
  endgenerate
`else
  assign w_cmd_latch = COMMAND;
`endif

  // Last period index of the current segment.
  always_comb begin
    w_seg_last = '0;
    case (r_state)
      S_START:  w_seg_last = PER_W'(START_BURST - 1);
      S_CARSEL: w_seg_last = PER_W'(CARSEL_BURST - 1);
      S_GAP:    w_seg_last = PER_W'(GAP - 1);
      S_BIT:    w_seg_last = r_cmd[r_idx] ? PER_W'(ASSERT_BURST - 1)
                                          : PER_W'(DEASSERT_BURST - 1);
      default:  w_seg_last = '0;
    endcase
  end

  // A period ends at the end of its low half, so segments always start high.
  assign w_half_end = (r_ph_cnt == PH_W'(CARRIER_HALF - 1));
  assign w_per_end  = w_half_end && !r_phase;
  assign w_seg_end  = w_per_end && (r_per_cnt == w_seg_last);
  assign w_last_bit = (r_idx == IDX_W'(NUM_CMD_BITS - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_ret_nxt     = r_ret;
    w_cmd_nxt     = r_cmd;
    w_idx_nxt     = r_idx;
    w_ph_cnt_nxt  = r_ph_cnt;
    w_phase_nxt   = r_phase;
    w_per_cnt_nxt = r_per_cnt;
    case (r_state)
      // FINISH accepts a held request directly so back-to-back packets are
      // separated by exactly the single FINISH cycle.
      S_IDLE, S_FINISH: begin
        w_state_nxt = S_IDLE;
        if (SEND_PACKET) begin
          w_state_nxt   = S_START;
          w_cmd_nxt     = w_cmd_latch;
          w_idx_nxt     = '0;
          w_ph_cnt_nxt  = '0;
          w_phase_nxt   = 1'b1;
          w_per_cnt_nxt = '0;
        end
      end
      S_START, S_GAP, S_CARSEL, S_BIT: begin
        if (w_half_end) begin
          w_ph_cnt_nxt = '0;
          w_phase_nxt  = !r_phase;
        end else begin
          w_ph_cnt_nxt = r_ph_cnt + PH_W'(1);
        end
        if (w_per_end) begin
          w_per_cnt_nxt = w_seg_end ? '0 : r_per_cnt + PER_W'(1);
        end
        if (w_seg_end) begin
          case (r_state)
            S_START: begin
              w_state_nxt = S_GAP;
              w_ret_nxt   = S_CARSEL;
            end
            S_CARSEL: begin
              w_state_nxt = S_GAP;
              w_ret_nxt   = S_BIT;
            end
            S_GAP: w_state_nxt = r_ret;
            default: begin
              if (w_last_bit) begin
                w_state_nxt = S_FINISH;
              end else begin
                w_state_nxt = S_GAP;
                w_ret_nxt   = S_BIT;
                w_idx_nxt   = r_idx + IDX_W'(1);
              end
            end
          endcase
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_led_nxt = w_phase_nxt &&
                     ((w_state_nxt == S_START) || (w_state_nxt == S_CARSEL) ||
                      (w_state_nxt == S_BIT));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_ret     <= S_IDLE;
      r_cmd     <= '0;
      r_idx     <= '0;
      r_ph_cnt  <= '0;
      r_phase   <= 1'b0;
      r_per_cnt <= '0;
      r_led     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ret     <= w_ret_nxt;
      r_cmd     <= w_cmd_nxt;
      r_idx     <= w_idx_nxt;
      r_ph_cnt  <= w_ph_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_per_cnt <= w_per_cnt_nxt;
      r_led     <= w_led_nxt;
    end
  end

  assign BUSY   = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign DONE   = (r_state == S_FINISH);
  assign IR_LED = r_led;

endmodule

// File: tb/tb_ir_packet_tx.sv
// Self-checking bench for ir_packet_tx with small parameters.
// A packet-level model expands each accepted command into the expected
// per-cycle {BUSY, IR_LED, DONE} sequence; a compare process checks every
// cycle, and directed scenarios check hand-computed totals.
module tb_ir_packet_tx;

  localparam int unsigned CH  = 2;
  localparam int unsigned SB  = 4;
  localparam int unsigned CSB = 2;
  localparam int unsigned GP  = 1;
  localparam int unsigned AB  = 2;
  localparam int unsigned DB  = 1;
  localparam int unsigned NB  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] cmd = '0;
  logic          send = 1'b0;
  logic          busy, done, led;

  int n_cmp = 0;
  int n_err = 0;
  int n_print = 0;
  bit chk_en = 1'b0;

  ir_packet_tx #(
    .CARRIER_HALF(CH), .START_BURST(SB), .CARSEL_BURST(CSB), .GAP(GP),
    .ASSERT_BURST(AB), .DEASSERT_BURST(DB), .NUM_CMD_BITS(NB)
  ) dut (
    .CLK(clk), .RESET(rst_n), .COMMAND(cmd), .SEND_PACKET(send),
    .BUSY(busy), .DONE(done), .IR_LED(led)
  );

  always #5 clk = ~clk;

  // ---------------- packet-level model ----------------
  logic [2:0] fut[$];          // {busy, led, done} for future cycles
  logic [2:0] cur = 3'b000;    // expected outputs in the current cycle

  task automatic push_seg(input int unsigned periods, input bit burst);
    for (int unsigned p = 0; p < periods; p++)
      for (int unsigned k = 0; k < 2 * CH; k++)
        fut.push_back({1'b1, (burst && (k < CH)), 1'b0});
  endtask

  task automatic build_packet(input logic [NB-1:0] c_in);
    logic [NB-1:0] c;
    c = c_in;
`ifdef IR_CMD_SANITISE_EN
    if (c[0] && c[1]) c[1:0] = 2'b00;
    if (c[2] && c[3]) c[3:2] = 2'b00;
`endif
    push_seg(SB, 1'b1);
    push_seg(GP, 1'b0);
    push_seg(CSB, 1'b1);
    push_seg(GP, 1'b0);
    for (int unsigned b = 0; b < NB; b++) begin
      push_seg(c[b] ? AB : DB, 1'b1);
      if (b != NB - 1) push_seg(GP, 1'b0);
    end
    fut.push_back(3'b001);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      fut.delete();
      cur = 3'b000;
    end else if (!cur[2] && send) begin
      fut.delete();
      build_packet(cmd);
      cur = fut.pop_front();
    end else if (fut.size() > 0) begin
      cur = fut.pop_front();
    end else begin
      cur = 3'b000;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({busy, led, done} !== cur) begin
        n_err++;
        if (n_print < 30) begin
          n_print++;
          $display("FAIL cycle_model t=%0t busy/led/done got %b expected %b",
                   $time, {busy, led, done}, cur);
        end
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Observe from the acceptance edge: cycle i is sampled at the i-th negedge.
  task automatic observe(input int max_cyc, input int n_done_stop,
                         output int nb, output int nh, output int nd,
                         output int d1, output int d2);
    nb = 0; nh = 0; nd = 0; d1 = 0; d2 = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (led) nh++;
      if (done) begin
        nd++;
        if (nd == 1) d1 = i;
        if (nd == 2) d2 = i;
      end
      if (nd >= n_done_stop && n_done_stop > 0) begin
        if (i >= ((nd == 1) ? d1 : d2) + 2) break;
      end
    end
  endtask

  task automatic run_packet(input string name, input logic [NB-1:0] c,
                            input int exp_busy, input int exp_high);
    int nb, nh, nd, d1, d2;
    @(posedge clk); #1;
    cmd = c; send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    observe(300, 1, nb, nh, nd, d1, d2);
    check({name, "_busy_cycles"}, nb, exp_busy);
    check({name, "_led_high"}, nh, exp_high);
    check({name, "_done_count"}, nd, 1);
    check({name, "_done_cycle"}, d1, exp_busy + 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nb, nh, nd, d1, d2;

    // Reset state
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_led", int'(led), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    run_packet("cmd0001", 4'b0001, 64, 22);
    run_packet("cmd0000", 4'b0000, 60, 20);
    run_packet("cmd1111", 4'b1111, 76, 28);
`ifdef IR_CMD_SANITISE_EN
    run_packet("cmd0011", 4'b0011, 60, 20);
`else
    run_packet("cmd0011", 4'b0011, 68, 24);
`endif

    // Reset in the middle of a packet
    @(posedge clk); #1;
    cmd = 4'b0001; send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_busy", int'(busy), 0);
    check("midreset_led", int'(led), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    observe(80, 0, nb, nh, nd, d1, d2);
    check("midreset_no_done", nd, 0);
    run_packet("after_reset", 4'b0001, 64, 22);

    // Held request with a command change mid-packet
    @(posedge clk); #1;
    cmd = 4'b0001; send = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        repeat (30) @(posedge clk);
        #1 cmd = 4'b1111;
        repeat (70) @(posedge clk);
        #1 send = 1'b0;
      end
      observe(400, 2, nb, nh, nd, d1, d2);
    join
    check("held_done_count", nd, 2);
    check("held_first_done", d1, 65);
    check("held_second_done", d2, 65 + 76 + 1);
    check("held_busy_cycles", nb, 64 + 76);
    check("held_led_high", nh, 22 + 28);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
